// File: rtl/button_filter_multi_if.sv
// Button filter bus: raw pins in, debounced level and event pulses out.
interface button_filter_multi_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] btn_o;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_repeat;
  logic             any_pressed;

  // Board/stimulus side: drives the pins, observes the events.
  modport master (
    output btn_i,
    input  btn_o, btn_press, btn_release, btn_long, btn_repeat, any_pressed
  );

  // Filter side.
  modport slave (
    input  btn_i,
    output btn_o, btn_press, btn_release, btn_long, btn_repeat, any_pressed
  );
endinterface

// File: rtl/button_filter_multi.sv
// Multi-channel push-button filter: synchroniser, debounce, press/release
// events, long-press and auto-repeat per channel. Channels share nothing.
//
// Hold FSM states (per channel):
//   state  | meaning
//   S_IDLE | debounced level released, no hold timing
//   S_HELD | pressed, counting towards the long-press event
//   S_LONG | long press reported, counting repeat intervals
module button_filter_multi #(
  parameter int N_BTN       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_PRDS   = 1000,
  parameter bit PRESS_LEVEL = 1'b0,
  parameter int LONG_PRDS   = 100000,
  parameter int REPEAT_PRDS = 20000
) (
  input logic                  clk,
  input logic                  rst_n,
  button_filter_multi_if.slave bus
);

  localparam int HOLD_MAX = (LONG_PRDS > REPEAT_PRDS) ? LONG_PRDS : REPEAT_PRDS;
  localparam int FW       = $clog2(FILT_PRDS);
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic          REL     = ~PRESS_LEVEL;
  localparam logic [FW-1:0] FILT_TC = FW'(FILT_PRDS - 1);
  localparam logic [HW-1:0] LONG_TC = HW'(LONG_PRDS);
  localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_PRDS);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

  logic [SYNC_STAGES-1:0] sync_q [N_BTN];
  logic [N_BTN-1:0]       sync_s;
  logic [FW-1:0]          filt_q [N_BTN];
  logic [FW-1:0]          filt_d [N_BTN];
  logic [HW-1:0]          hold_q [N_BTN];
  logic [HW-1:0]          hold_d [N_BTN];
  state_t                 state_q [N_BTN];
  state_t                 state_d [N_BTN];
  logic [N_BTN-1:0]       btn_q, btn_d;
  logic [N_BTN-1:0]       press_q, press_d;
  logic [N_BTN-1:0]       release_q, release_d;
  logic [N_BTN-1:0]       long_q, long_d;
  logic [N_BTN-1:0]       rep_q, rep_d;
  logic                   any_q, any_d;

  // Synchroniser chains; reset to the released level so no event fires on reset exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) sync_q[i] <= {SYNC_STAGES{REL}};
    end else begin
      for (int i = 0; i < N_BTN; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.btn_i[i]};
    end
  end

  // Last synchroniser stage per channel.
  always_comb begin
    sync_s = '0;
    for (int i = 0; i < N_BTN; i++) sync_s[i] = sync_q[i][SYNC_STAGES-1];
  end

  // Debounce: a differing level must persist FILT_PRDS cycles; any agreeing cycle restarts.
  always_comb begin
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      filt_d[i] = '0;
      if (sync_s[i] != btn_q[i]) begin
        if (filt_q[i] == FILT_TC) begin
          btn_d[i]     = sync_s[i];
          press_d[i]   = (sync_s[i] == PRESS_LEVEL);
          release_d[i] = (sync_s[i] != PRESS_LEVEL);
        end else begin
          filt_d[i] = filt_q[i] + 1'b1;
        end
      end
    end
  end

  // Hold FSM next state. The hold counter counts held cycles including the
  // current one, so it restarts at 1 after each long/repeat event; an accepted
  // release pre-empts any long/repeat pulse due in the same cycle.
  always_comb begin
    long_d = '0;
    rep_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (press_d[i]) begin
            state_d[i] = S_HELD;
            hold_d[i]  = HW'(1);
          end
        end
        S_HELD: begin
          if (release_d[i]) begin
            state_d[i] = S_IDLE;
            hold_d[i]  = '0;
          end else if (hold_q[i] == LONG_TC) begin
            long_d[i]  = 1'b1;
            state_d[i] = S_LONG;
            hold_d[i]  = HW'(1);
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
        S_LONG: begin
          if (release_d[i]) begin
            state_d[i] = S_IDLE;
            hold_d[i]  = '0;
          end else if (REPEAT_PRDS != 0) begin
            if (hold_q[i] == REP_TC) begin
              rep_d[i]  = 1'b1;
              hold_d[i] = HW'(1);
            end else begin
              hold_d[i] = hold_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  // Registered "any channel pressed" summary, one cycle behind btn_o.
  always_comb begin
    any_d = |(~(btn_q ^ {N_BTN{PRESS_LEVEL}}));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        filt_q[i]  <= '0;
        hold_q[i]  <= '0;
        state_q[i] <= S_IDLE;
      end
      btn_q     <= {N_BTN{REL}};
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      rep_q     <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        filt_q[i]  <= filt_d[i];
        hold_q[i]  <= hold_d[i];
        state_q[i] <= state_d[i];
      end
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      any_q     <= any_d;
    end
  end

  assign bus.btn_o       = btn_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_long    = long_q;
  assign bus.btn_repeat  = rep_q;
  assign bus.any_pressed = any_q;

endmodule

// File: tb/tb_button_filter_multi.sv
// Bench for button_filter_multi: cycle-by-cycle comparison against a
// run-length / elapsed-time model, plus directed event-timing checks.
module tb_button_filter_multi;
  localparam int NB    = 2;
  localparam int SYNC  = 2;
  localparam int FILT  = 8;
  localparam int LONG  = 20;
  localparam int REP   = 5;
  localparam bit PRESS = 1'b0;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  button_filter_multi_if #(.N_BTN(NB)) bus ();

  button_filter_multi #(
    .N_BTN(NB), .SYNC_STAGES(SYNC), .FILT_PRDS(FILT),
    .PRESS_LEVEL(PRESS), .LONG_PRDS(LONG), .REPEAT_PRDS(REP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin samples are delayed by SYNC edges; a level is accepted once the last
  // FILT delayed samples all differ from the current output. Long/repeat are
  // derived from the number of cycles elapsed since the accepted press.
  bit          m_raw [NB][SYNC];
  bit          m_sh  [NB][FILT];
  int          m_fill[NB];
  bit          m_out [NB];
  int          m_age [NB];
  logic [NB-1:0] e_btn, e_press, e_rel, e_long, e_rep;
  logic          e_any;

  task automatic mdl_reset();
    for (int c = 0; c < NB; c++) begin
      for (int j = 0; j < SYNC; j++) m_raw[c][j] = ~PRESS;
      for (int j = 0; j < FILT; j++) m_sh[c][j] = 1'b0;
      m_fill[c] = 0;
      m_out[c]  = ~PRESS;
      m_age[c]  = 0;
    end
    e_btn = {NB{~PRESS}};
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_any = 1'b0;
  endtask

  task automatic mdl_step();
    bit was_any;
    bit s;
    bit differ;
    was_any = 1'b0;
    for (int c = 0; c < NB; c++) if (m_out[c] == PRESS) was_any = 1'b1;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int c = 0; c < NB; c++) begin
      s = m_raw[c][0];
      for (int j = 0; j < SYNC-1; j++) m_raw[c][j] = m_raw[c][j+1];
      m_raw[c][SYNC-1] = bus.btn_i[c];
      for (int j = 0; j < FILT-1; j++) m_sh[c][j] = m_sh[c][j+1];
      m_sh[c][FILT-1] = s;
      if (m_fill[c] < FILT) m_fill[c]++;
      differ = (m_fill[c] == FILT);
      for (int j = 0; j < FILT; j++) if (m_sh[c][j] == m_out[c]) differ = 1'b0;
      if (differ) begin
        m_out[c] = s;
        if (s == PRESS) begin
          e_press[c] = 1'b1;
          m_age[c] = 0;
        end else begin
          e_rel[c] = 1'b1;
        end
      end else if (m_out[c] == PRESS) begin
        m_age[c]++;
        if (m_age[c] == LONG) e_long[c] = 1'b1;
        else if (REP > 0 && m_age[c] > LONG && ((m_age[c] - LONG) % REP) == 0) e_rep[c] = 1'b1;
      end
      e_btn[c] = m_out[c];
    end
    e_any = was_any;
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else mdl_step();
    end
  end

  // ---------------- event log + per-cycle compare ----------------
  int last_press[NB], last_rel[NB], last_long[NB];
  int press_n[NB], rel_n[NB], long_n[NB], rep_n[NB];
  int rep_t[NB][8];
  int low0_n = 0;

  initial begin
    for (int c = 0; c < NB; c++) begin
      last_press[c] = -1; last_rel[c] = -1; last_long[c] = -1;
      press_n[c] = 0; rel_n[c] = 0; long_n[c] = 0; rep_n[c] = 0;
      for (int j = 0; j < 8; j++) rep_t[c][j] = -1;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NB; c++) begin
        if (bus.btn_press[c])   begin last_press[c] = cyc; press_n[c]++; end
        if (bus.btn_release[c]) begin last_rel[c] = cyc;   rel_n[c]++;   end
        if (bus.btn_long[c])    begin last_long[c] = cyc;  long_n[c]++;  end
        if (bus.btn_repeat[c])  begin
          if (rep_n[c] < 8) rep_t[c][rep_n[c]] = cyc;
          rep_n[c]++;
        end
      end
      if (!bus.btn_o[0]) low0_n++;
      chk("btn_o",       int'(bus.btn_o),       int'(e_btn));
      chk("btn_press",   int'(bus.btn_press),   int'(e_press));
      chk("btn_release", int'(bus.btn_release), int'(e_rel));
      chk("btn_long",    int'(bus.btn_long),    int'(e_long));
      chk("btn_repeat",  int'(bus.btn_repeat),  int'(e_rep));
      chk("any_pressed", int'(bus.any_pressed), int'(e_any));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  int t0, t1, t2, t3, t4, t5;

  initial begin
    rst_n = 1'b0;
    bus.btn_i = 2'b11;
    wait_cyc(3);
    rst_n = 1'b1;

    // Idle after reset with pins released.
    wait_cyc(1);
    chk("rst_btn_o", int'(bus.btn_o), 3);
    chk("rst_any", int'(bus.any_pressed), 0);
    wait_cyc(50);
    chk("idle_btn_o", int'(bus.btn_o), 3);
    chk("idle_pulses", press_n[0] + press_n[1] + rel_n[0] + rel_n[1] + long_n[0] + long_n[1], 0);

    // Bounce: low 7 cycles, high 1 cycle never reaches the filter time.
    for (int k = 0; k < 13; k++) begin
      bus.btn_i[0] = 1'b0;
      wait_cyc(7);
      bus.btn_i[0] = 1'b1;
      wait_cyc(1);
    end
    wait_cyc(15);
    chk("bounce_low_cycles", low0_n, 0);
    chk("bounce_press_n", press_n[0], 0);

    // Clean press on ch0, hold through long and repeats, then release.
    t0 = cyc;
    bus.btn_i[0] = 1'b0;
    wait_cyc(12);
    chk("press_latency", last_press[0] - t0, 10);
    chk("ch1_unaffected", int'(bus.btn_o[1]), 1);
    chk("any_after_press", int'(bus.any_pressed), 1);
    wait_cyc(25);
    t1 = cyc;
    chk("release_drive_time", t1 - t0, 37);
    bus.btn_i[0] = 1'b1;
    wait_cyc(33);
    chk("long_after_press", last_long[0] - last_press[0], 20);
    chk("rep1", rep_t[0][0] - last_long[0], 5);
    chk("rep2", rep_t[0][1] - last_long[0], 10);
    chk("rep3", rep_t[0][2] - last_long[0], 15);
    chk("release_latency", last_rel[0] - t1, 10);
    chk("rep_count", rep_n[0], 3);
    chk("long_count0", long_n[0], 1);

    // Both channels pressed on the same edge.
    t2 = cyc;
    bus.btn_i = 2'b00;
    wait_cyc(12);
    chk("dual_press0", last_press[0] - t2, 10);
    chk("dual_press1", last_press[1] - t2, 10);
    wait_cyc(20);
    chk("dual_long0", last_long[0] - t2, 30);
    chk("dual_long1", last_long[1] - t2, 30);
    bus.btn_i = 2'b11;
    wait_cyc(28);

    // Ch1 release accepted on the cycle its long press would fire.
    t3 = cyc;
    bus.btn_i[1] = 1'b0;
    wait_cyc(20);
    bus.btn_i[1] = 1'b1;
    wait_cyc(15);
    chk("race_press1", last_press[1] - t3, 10);
    chk("race_release1", last_rel[1] - t3, 30);
    chk("race_long_n1", long_n[1], 1);

    // Reset mid-LONG with ch0 held.
    t4 = cyc;
    bus.btn_i[0] = 1'b0;
    wait_cyc(33);
    chk("pre_rst_long", last_long[0] - t4, 30);
    chk("pre_rst_btn_o", int'(bus.btn_o), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_btn_o", int'(bus.btn_o), 3);
    chk("rst_mid_any", int'(bus.any_pressed), 0);
    chk("rst_mid_pulses", int'({bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_repeat}), 0);
    wait_cyc(3);
    chk("rst_no_release", rel_n[0], 2);
    rst_n = 1'b1;
    t5 = cyc;
    wait_cyc(35);
    chk("redetect_press", last_press[0] - t5, 10);
    chk("redetect_long", last_long[0] - t5, 30);
    chk("rst_no_release_end", rel_n[0], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
